// File: rtl/mips_dbg_pkg.sv
// Shared debug-path definitions for the single-cycle MIPS core.
// `REGFILE_DUMP_CHECKSUM_EN is left undefined by default; define it to append an XOR checksum beat to each dump.
package mips_dbg_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [2:0] {
        DUMP_IDLE,
        DUMP_FETCH,
        DUMP_SEND0,
        DUMP_SEND1,
        DUMP_CSUM,
        DUMP_DONE
    } dump_state_t;

endpackage

// File: rtl/dump_xor_accum.sv
// Running XOR accumulator used to build the register dump checksum.
module dump_xor_accum #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] data,
    output logic [W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc ^ data;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Streams every register-file word, two per fetch, out over a valid/ready debug port.
// Optional checksum beat is enabled by defining `REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_reader #(
    parameter int DATA_W   = mips_dbg_pkg::REG_DATA_W,
    parameter int ADDR_W   = mips_dbg_pkg::REG_ADDR_W,
    parameter int NUM_REGS = mips_dbg_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    import mips_dbg_pkg::*;

    localparam int PAIRS = NUM_REGS / 2;
    localparam int K_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(PAIRS - 1);

    dump_state_t       state;
    dump_state_t       state_next;
    logic [K_W-1:0]    k;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic [ADDR_W-1:0] addr_even;
    logic [ADDR_W-1:0] addr_odd;
    logic              last_pair;
    logic              fire;

    assign addr_even = ADDR_W'({k, 1'b0});
    assign addr_odd  = ADDR_W'({k, 1'b1});
    assign last_pair = (k == K_LAST);
    assign fire      = out_valid && out_ready && !abort;
    assign busy      = (state != DUMP_IDLE);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    dump_xor_accum #(
        .W(DATA_W)
    ) u_xor_accum (
        .clk   (clk),
        .rst   (rst),
        .clear (state == DUMP_IDLE && start),
        .enable(fire && (state == DUMP_SEND0 || state == DUMP_SEND1)),
        .data  ((state == DUMP_SEND1) ? buf1 : buf0),
        .acc   (csum)
    );
`endif

    // Buffers only load in FETCH, so beat contents stay frozen through any stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DUMP_IDLE;
            k     <= '0;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            state <= state_next;
            if (state == DUMP_IDLE && start) begin
                k <= '0;
            end else if (state == DUMP_SEND1 && fire && !last_pair) begin
                k <= k + 1'b1;
            end
            if (state == DUMP_FETCH) begin
                buf0 <= rd_data_a;
                buf1 <= rd_data_b;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DUMP_IDLE:  if (start) state_next = DUMP_FETCH;
            DUMP_FETCH: state_next = DUMP_SEND0;
            DUMP_SEND0: if (out_ready) state_next = DUMP_SEND1;
            DUMP_SEND1: begin
                if (out_ready) begin
                    if (!last_pair) begin
                        state_next = DUMP_FETCH;
                    end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        state_next = DUMP_CSUM;
`else
                        state_next = DUMP_DONE;
`endif
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            DUMP_CSUM:  if (out_ready) state_next = DUMP_DONE;
`endif
            DUMP_DONE:  state_next = DUMP_IDLE;
            default:    state_next = DUMP_IDLE;
        endcase
        if (abort && state != DUMP_IDLE) begin
            state_next = DUMP_IDLE;
        end
    end

    always_comb begin
        rd_addr_a = '0;
        rd_addr_b = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        case (state)
            DUMP_FETCH: begin
                rd_addr_a = addr_even;
                rd_addr_b = addr_odd;
            end
            DUMP_SEND0: begin
                out_valid = 1'b1;
                out_data  = buf0;
                out_index = addr_even;
            end
            DUMP_SEND1: begin
                out_valid = 1'b1;
                out_data  = buf1;
                out_index = addr_odd;
`ifndef REGFILE_DUMP_CHECKSUM_EN
                out_last  = last_pair;
`endif
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            DUMP_CSUM: begin
                out_valid = 1'b1;
                out_data  = csum;
                out_last  = 1'b1;
            end
`endif
            DUMP_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a reference register array feeds expected beats to a queue
// that a negedge monitor drains. Honours `REGFILE_DUMP_CHECKSUM_EN when defined.
module tb_regfile_dump_reader;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
    localparam int EXP_CYCLES = 50;
`else
    localparam bit CSUM_ON = 1'b0;
    localparam int EXP_CYCLES = 49;
`endif

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        out_ready;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    beat_t       exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ready_mode = 0;

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beats come straight from the register snapshot: index order, value as stored, XOR at the end.
    task automatic push_expected();
        logic [31:0] x;
        x = 32'h0;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back('{idx: 5'(i), data: regs[i], last: (!CSUM_ON && i == 31)});
            x ^= regs[i];
        end
        if (CSUM_ON) exp_q.push_back('{idx: 5'd0, data: x, last: 1'b1});
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_out_valid"}, out_valid, 0);
        check_output({tag, "_out_data"},  out_data,  0);
        check_output({tag, "_out_index"}, out_index, 0);
        check_output({tag, "_out_last"},  out_last,  0);
        check_output({tag, "_busy"},      busy,      0);
        check_output({tag, "_done"},      done,      0);
        check_output({tag, "_rd_addr_a"}, rd_addr_a, 0);
        check_output({tag, "_rd_addr_b"}, rd_addr_b, 0);
    endtask

    task automatic start_dump(input bit check_timing);
        push_expected();
        start = 1'b1;
        step();
        start = 1'b0;
        if (check_timing) begin
            check_output("fetch_busy", busy, 1);
            check_output("fetch_addr_a", rd_addr_a, 0);
            check_output("fetch_addr_b", rd_addr_b, 1);
            check_output("fetch_no_valid", out_valid, 0);
        end
    endtask

    // Waits for done, then also holds start high through the DONE cycle, which must be ignored.
    task automatic finish_dump(input bit check_timing, input int cycles_so_far);
        int cycles;
        cycles = cycles_so_far;
        while (done !== 1'b1 && cycles < 2000) begin
            step();
            cycles++;
        end
        check_output("done_seen", done, 1);
        if (check_timing) begin
            check_output("dump_cycles", cycles, EXP_CYCLES);
            check_output("busy_in_done", busy, 1);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check_output("start_in_done_ignored", busy, 0);
        step();
        check_output("idle_after_done", busy, 0);
        check_output("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic apply_stimulus(input int ready_m, input bit check_timing);
        ready_mode = ready_m;
        start_dump(check_timing);
        finish_dump(check_timing, 1);
    endtask

    initial begin
        int ph;
        logic [3:0] ready_pat;
        ph = 0;
        ready_pat = 4'b1001;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    out_ready = ready_pat[ph];
                    ph = (ph + 1) % 4;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops on every accepted beat, checks stall stability and the done pulse after the last beat.
    initial begin
        beat_t       e;
        logic        stall_prev;
        logic        exp_done;
        logic [31:0] prev_data;
        logic [4:0]  prev_idx;
        logic        prev_last;
        stall_prev = 1'b0;
        exp_done = 1'b0;
        prev_data = '0;
        prev_idx = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                stall_prev = 1'b0;
                exp_done = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_output("stall_valid", out_valid, 1);
                    check_output("stall_data", out_data, prev_data);
                    check_output("stall_index", out_index, prev_idx);
                    check_output("stall_last", out_last, prev_last);
                end
                if (exp_done || done === 1'b1) check_output("done_pulse", done, exp_done);
                exp_done = 1'b0;
                stall_prev = out_valid && !out_ready && !abort;
                prev_data = out_data;
                prev_idx = out_index;
                prev_last = out_last;
                if (out_valid && out_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("beat_index", out_index, e.idx);
                        check_output("beat_data", out_data, e.data);
                        check_output("beat_last", out_last, e.last);
                        exp_done = e.last;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0000_0100 + i;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b1;
        step();

        // Incrementing preload, ready held high, with latency and cycle-count checks.
        apply_stimulus(0, 1'b1);

        // Same preload with a 1-0-0-1 ready pattern.
        apply_stimulus(1, 1'b0);

        // Single non-zero register; the checksum beat equals it when enabled.
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[5] = 32'hDEAD_BEEF;
        apply_stimulus(0, 1'b1);

        // Abort during SEND1 of pair 7, then a fresh dump must restart at index 0.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        ready_mode = 0;
        start_dump(1'b0);
        n = 0;
        while (!(out_valid === 1'b1 && out_index === 5'd15) && n < 500) begin
            step();
            n++;
        end
        check_output("reach_send1_pair7", out_index, 15);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_output("abort_valid", out_valid, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("abort_stays_idle", busy, 0);
        end
        apply_stimulus(0, 1'b1);

        // Reset in the middle of a dump.
        start_dump(1'b0);
        for (int i = 0; i < 20; i++) step();
        rst = 1'b0;
        step();
        check_idle_outputs("mid_reset");
        step();
        rst = 1'b1;
        exp_q.delete();
        step();
        apply_stimulus(0, 1'b1);

        // Register write coinciding with the FETCH edge of pair 2 is not seen by this dump.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        ready_mode = 0;
        start_dump(1'b0);
        n = 0;
        while (rd_addr_a !== 5'd4 && n < 500) begin
            step();
            n++;
        end
        check_output("fetch_pair2_addr_b", rd_addr_b, 5);
        @(posedge clk);
        regs[4] <= 32'hCAFE_0000;
        #1;
        finish_dump(1'b0, 1);
        apply_stimulus(0, 1'b0);

        // Randomized contents with random backpressure.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            apply_stimulus(2, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
